// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Holds every downstream reset asserted until the PLL has been locked for
//   HOLD_CYCLES. It then releases the channels one at a time in ascending
//   order, STAGGER_CYCLES apart. Once all channels are out of reset, the
//   block watches for a re-trigger:
//     - PLL loss
//     - software request
//     - optional watchdog timeout
//   A re-trigger restarts the whole sequence and records its cause.
//
//   Optional feature: define RSTSEQ_WDT_EN to build the watchdog. Without it,
//   wdt_kick is accepted but has no effect.
//
// Ports
//   clk         block clock; all logic is rising-edge
//   rst_n       asynchronous active-low reset
//   pll_locked  PLL lock; asynchronous to clk and synchronized inside
//   sw_rst_req  software reset request, level-sampled in RELEASE/RUN
//   wdt_kick    watchdog restart strobe
//   rst_n_out   per-channel active-low resets (registered)
//   seq_done    high once every channel has been released
//   rst_cause   cause of the last reset: 00 POR, 01 PLL loss, 10 sw, 11 wdt

// One registered reset output. Release is sticky until a global clear.
module reset_seq_chan (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic set,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (set) q <= 1'b1;
  end
endmodule

module reset_sequencer #(
  parameter int NCH            = 3,
  parameter int CNT_W          = 16,
  parameter int HOLD_CYCLES    = 255,
  parameter int STAGGER_CYCLES = 16,
  parameter int WDT_CYCLES     = 65535
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pll_locked,
  input  logic           sw_rst_req,
  input  logic           wdt_kick,
  output logic [NCH-1:0] rst_n_out,
  output logic           seq_done,
  output logic [1:0]     rst_cause
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NCH - 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_PLL = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Lock synchronizer. It powers up as "unlocked", so a POR always starts
  // with a full hold count.
  logic [1:0] sync_pipe;
  logic       lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= 2'b00;
    else        sync_pipe <= {sync_pipe[0], pll_locked};
  end
  assign lock_s = sync_pipe[1];

  // Watchdog
  logic wdt_to;

`ifdef RSTSEQ_WDT_EN
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);
  logic [CNT_W-1:0] wdt_q;

  // The counter is held at 0 outside RUN, so it is already clear when RUN
  // is entered. A kick in the terminal cycle takes precedence over the
  // timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            wdt_q <= '0;
    else if (state_q != ST_RUN || wdt_kick) wdt_q <= '0;
    else                                   wdt_q <= wdt_q + 1'b1;
  end

  assign wdt_to = (state_q == ST_RUN) && (wdt_q == WDT_LAST) && !wdt_kick;
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
  assign wdt_to          = 1'b0;
`endif

  // Re-trigger detection. A re-trigger only matters outside ASSERT. When
  // several sources are active, only the highest-priority cause is kept.
  logic       retrig;
  logic [1:0] cause_nxt;

  assign retrig = !lock_s || wdt_to || sw_rst_req;

  always_comb begin
    if (!lock_s)     cause_nxt = CAUSE_PLL;
    else if (wdt_to) cause_nxt = CAUSE_WDT;
    else             cause_nxt = CAUSE_SW;
  end

  // Shared hold/stagger counter, next-channel index, and registered flags
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [1:0]       cause_q, cause_d;
  logic [NCH-1:0]   rel_set;
  logic             clr_all;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ASSERT;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ASSERT:
        if (lock_s && cnt_q == HOLD_LAST) begin
          state_d = (NCH == 1) ? ST_RUN : ST_RELEASE;
        end
      ST_RELEASE:
        if (retrig)                                       state_d = ST_ASSERT;
        else if (cnt_q == STAG_LAST && idx_q == LAST_IDX) state_d = ST_RUN;
      ST_RUN:
        if (retrig) state_d = ST_ASSERT;
      default:
        state_d = ST_ASSERT;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = done_q;
    cause_d = cause_q;
    rel_set = '0;
    clr_all = 1'b0;
    unique case (state_q)
      ST_ASSERT: begin
        // Any drop of lock restarts the hold window. The cause was already
        // recorded when the re-trigger fired.
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d      = '0;
          rel_set[0] = 1'b1;
          idx_d      = IDX_W'(1);
          done_d     = (NCH == 1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (retrig) begin
          clr_all = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
          done_d  = 1'b0;
          cause_d = cause_nxt;
        end else if (cnt_q == STAG_LAST) begin
          cnt_d          = '0;
          rel_set[idx_q] = 1'b1;
          idx_d          = idx_q + 1'b1;
          done_d         = (idx_q == LAST_IDX);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (retrig) begin
          clr_all = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
          done_d  = 1'b0;
          cause_d = cause_nxt;
        end
      end
      default: begin
        clr_all = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  // Per-channel reset registers
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    reset_seq_chan u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_all),
      .set   (rel_set[k]),
      .q     (rst_n_out[k])
    );
  end

  assign seq_done  = done_q;
  assign rst_cause = cause_q;

endmodule
